uno_dealer: RTL and testbench
=============================

# uno_dealer

Card-distribution stage directly downstream of the deck: issues draw-count requests to the deck, captures each card it emits, and stores it in per-player hand buffers. Performs the opening deal (INIT_CARDS per player, round-robin) and runtime draw-1/2/4 penalties. Supports removal of played cards and random-access hand readout for the game controller and display logic.

## Interface
- NUM_PLAYERS, 4: number of hands (2..4)
- HAND_CAP, 32: slots per hand (power of two)
- INIT_CARDS, 7: cards per player in opening deal
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_deal_start  in  1  pulse: start opening deal
- i_req  in  1  runtime draw request, accepted when o_req_ready
- i_req_player  in  2  target hand for i_req
- i_req_count  in  3  cards to draw (0..7; game uses 1, 2, 4)
- o_req_ready  out  1  state==S_IDLE && !i_play
- i_play  in  1  remove a card from a hand (S_IDLE only)
- i_play_player  in  2  hand for i_play
- i_play_idx  in  5  slot for i_play
- o_played_card  out  6  registered copy of removed card
- o_busy  out  1  state!=S_IDLE
- o_done  out  1  one-cycle pulse on completion of deal or draw
- o_overflow  out  1  sticky: card arrived for a full hand
- o_deck_draw  out  3  draw count to deck, driven for exactly one cycle
- i_deck_done  in  1  deck idle, ready for a count
- i_deck_drawn  in  1  deck card valid this cycle
- i_deck_card  in  6  {color[1:0], value[3:0]}
- i_rd_player  in  2  readout hand select
- i_rd_idx  in  5  readout slot
- o_rd_card  out  6  combinational hand[i_rd_player][i_rd_idx]
- o_rd_count  out  6  combinational card count of i_rd_player
- o_top_card  out  6  starter card (only with UNO_DEALER_FIRST_CARD_EN)

## Operation
- States: S_IDLE, S_ISSUE, S_WAIT, S_FIN.
- S_IDLE: i_play (priority) → hand[p][idx] replaced by hand[p][count-1], count−1, o_played_card←old card; idx ≥ count → ignored. Else i_deal_start → player=0, round=0, remaining=1, S_ISSUE. Else i_req → latch player/count; count=0 → S_FIN; else S_ISSUE.
- S_ISSUE: wait for i_deck_done; that cycle drive o_deck_draw=remaining, → S_WAIT. Otherwise o_deck_draw=0.
- S_WAIT: each i_deck_drawn writes i_deck_card to hand[player][count], count+1, remaining−1. Hand full → card dropped, o_overflow←1, remaining still decrements. remaining reaches 0: deal mode → advance player (wrap at NUM_PLAYERS−1 → round+1); round==INIT_CARDS → S_FIN, else S_ISSUE with remaining=1. Draw mode → S_FIN.
- S_FIN: o_done=1 one cycle → S_IDLE.
- i_deal_start/i_req/i_play outside S_IDLE: ignored.
- Opening deal clears all counts and o_overflow at entry.
- Reset: state S_IDLE, all counts 0, hand contents 0, o_deck_draw 0, o_done 0, o_overflow 0, o_played_card 0, o_top_card 0; o_busy 0, o_req_ready 1.

## Timing
- Request accept → o_deck_draw: ≥1 cycle (next cycle with i_deck_done).
- Card captured the same edge i_deck_drawn is high; visible on o_rd_card next cycle.
- Last card captured → o_done two cycles later (S_FIN, then idle).
- Full deal, deck answering every other cycle: NUM_PLAYERS×INIT_CARDS issue/capture sequences, no back-to-back o_deck_draw.
- Reset mid-deal: all hands lost; deck must be reset with the same i_rst_n.

## Configuration
- UNO_DEALER_FIRST_CARD_EN defined: after the deal, state S_TOP issues draw 1 and loads o_top_card; value 13 or 14 (wild/wild-four) → redraw until a non-wild arrives; then S_FIN.
- Undefined: no S_TOP, o_top_card tied 0, deal ends after last hand card.

## Structure
- uno_pkg: card_t packed struct {color, value}; color/value localparams (VAL_SKIP=10, VAL_REV=11, VAL_DRAW2=12, VAL_WILD=13, VAL_WILD4=14); DRAW_ONE/TWO/FOUR = 3'd1/2/4; state enum.
- Sub-module uno_hand_store: one hand (HAND_CAP×card_t, count, append, swap-remove, read port), instantiated NUM_PLAYERS times.

## Test plan
- i_deal_start with deck model emitting 0x00..0x1B → hand0 = {0x00,0x04,…}, all o_rd_count=7, one o_done, 28 one-cycle o_deck_draw=1.
- Idle, i_req player2 count4 → single o_deck_draw=4, four captures, hand2 count 7→11, o_done once.
- Hand1 at 32, i_req count2 → o_overflow=1, count stays 32, o_done still pulses.
- i_play player0 idx2 with count 7 → o_played_card=old slot2, slot2=old slot6, count 6; idx 9 → no change.
- i_play and i_req same cycle → play executes, o_req_ready=0, request ignored.
- FIRST_CARD_EN, deck gives 0x0D then 0x25 after deal → o_top_card=0x25, two extra draws.

Source files
------------

// File: rtl/uno_pkg.sv
// Shared types and constants for the UNO dealer: card encoding, card values,
// draw counts and dealer state codes.
// Optional feature macro: UNO_DEALER_FIRST_CARD_EN adds the S_TOP state.
package uno_pkg;

    // Card as emitted by the deck: {color[1:0], value[3:0]}
    typedef struct packed {
        logic [1:0] color;
        logic [3:0] value;
    } card_t;

    localparam logic [1:0] COL_RED    = 2'd0;
    localparam logic [1:0] COL_YELLOW = 2'd1;
    localparam logic [1:0] COL_GREEN  = 2'd2;
    localparam logic [1:0] COL_BLUE   = 2'd3;

    localparam logic [3:0] VAL_SKIP  = 4'd10;
    localparam logic [3:0] VAL_REV   = 4'd11;
    localparam logic [3:0] VAL_DRAW2 = 4'd12;
    localparam logic [3:0] VAL_WILD  = 4'd13;
    localparam logic [3:0] VAL_WILD4 = 4'd14;

    localparam logic [2:0] DRAW_ONE  = 3'd1;
    localparam logic [2:0] DRAW_TWO  = 3'd2;
    localparam logic [2:0] DRAW_FOUR = 3'd4;

    // Dealer state codes, kept as plain constants for legacy tooling
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_ISSUE = 3'd1;
    localparam state_t S_WAIT  = 3'd2;
    localparam state_t S_FIN   = 3'd3;
`ifdef UNO_DEALER_FIRST_CARD_EN
    localparam state_t S_TOP   = 3'd4;
`endif

    // A wild or wild-four cannot be the starter card
    function automatic logic is_wild(input card_t c);
        return (c.value == VAL_WILD) || (c.value == VAL_WILD4);
    endfunction

endpackage

// File: rtl/uno_hand_store.sv
// One player's hand: HAND_CAP card slots plus a fill count. Supports
// append at the end, swap-remove (last card moves into the hole) and a
// combinational random-access read port.
module uno_hand_store
    import uno_pkg::*;
#(
    parameter int HAND_CAP = 32,
    localparam int IDX_W = $clog2(HAND_CAP),
    localparam int CNT_W = IDX_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_append,
    input  card_t            i_card,
    input  logic             i_remove,
    input  logic [IDX_W-1:0] i_remove_idx,
    output card_t            o_removed_card,
    output logic             o_remove_ok,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count,
    input  logic [IDX_W-1:0] i_rd_idx,
    output card_t            o_rd_card
);

    card_t            mem [HAND_CAP];
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] last_pos;

    assign last_pos       = count - 1'b1;
    assign o_full         = (count == CNT_W'(HAND_CAP));
    assign o_remove_ok    = ({1'b0, i_remove_idx} < count);
    assign o_removed_card = mem[i_remove_idx];
    assign o_count        = count;
    assign o_rd_card      = mem[i_rd_idx];

    // Slot storage and fill count; append and remove are never requested together
    // NOTE: the card array is reset too, so readout of never-written slots is a
    // defined zero after reset rather than whatever the flops powered up with.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
            for (int i = 0; i < HAND_CAP; i++) begin
                mem[i] <= '0;
            end
        end else if (i_clear) begin
            count <= '0;
        end else if (i_append && !o_full) begin
            mem[count[IDX_W-1:0]] <= i_card;
            count                 <= count + 1'b1;
        end else if (i_remove && o_remove_ok) begin
            mem[i_remove_idx] <= mem[last_pos[IDX_W-1:0]];
            count             <= last_pos;
        end
    end

endmodule

// File: rtl/uno_dealer.sv
// Card-distribution stage behind the deck: opening round-robin deal,
// runtime draw penalties, played-card removal and hand readout.
// Optional feature macro: UNO_DEALER_FIRST_CARD_EN draws a non-wild starter
// card onto o_top_card after the opening deal.
module uno_dealer
    import uno_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int HAND_CAP    = 32,
    parameter int INIT_CARDS  = 7
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_deal_start,
    input  logic       i_req,
    input  logic [1:0] i_req_player,
    input  logic [2:0] i_req_count,
    output logic       o_req_ready,
    input  logic       i_play,
    input  logic [1:0] i_play_player,
    input  logic [4:0] i_play_idx,
    output logic [5:0] o_played_card,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_overflow,
    output logic [2:0] o_deck_draw,
    input  logic       i_deck_done,
    input  logic       i_deck_drawn,
    input  logic [5:0] i_deck_card,
    input  logic [1:0] i_rd_player,
    input  logic [4:0] i_rd_idx,
    output logic [5:0] o_rd_card,
    output logic [5:0] o_rd_count,
    output logic [5:0] o_top_card
);

    localparam int IDX_W = $clog2(HAND_CAP);
    localparam int CNT_W = IDX_W + 1;
    localparam int RND_W = $clog2(INIT_CARDS + 1);
    localparam logic [1:0]       LAST_PLAYER = 2'(NUM_PLAYERS - 1);
    localparam logic [RND_W-1:0] LAST_ROUND  = RND_W'(INIT_CARDS - 1);

    state_t           state;
    logic [1:0]       player;
    logic [RND_W-1:0] round;
    logic [2:0]       remaining;
    logic             deal_mode;

    // Per-hand handshake; four lanes always exist, unused ones are tied off
    logic [3:0]       h_clear, h_append, h_remove, h_full, h_remove_ok;
    card_t            h_removed [4];
    card_t            h_rd      [4];
    logic [CNT_W-1:0] h_count   [4];

    logic play_fire, deal_fire, capture, deal_last;

    assign play_fire = (state == S_IDLE) && i_play;
    assign deal_fire = (state == S_IDLE) && !i_play && i_deal_start;
    assign capture   = (state == S_WAIT) && i_deck_drawn;
    assign deal_last = (player == LAST_PLAYER) && (round == LAST_ROUND);

    // Steer clear/append/remove strobes to the addressed hand
    // NOTE: every output gets a default before the loop so no path leaves a
    // strobe unassigned, which would otherwise infer a latch.
    always_comb begin
        h_clear  = '0;
        h_append = '0;
        h_remove = '0;
        for (int p = 0; p < 4; p++) begin
            h_clear[p]  = deal_fire;
            h_append[p] = capture && (player == 2'(p));
            h_remove[p] = play_fire && (i_play_player == 2'(p));
        end
    end

    for (genvar p = 0; p < 4; p++) begin : g_hand
        if (p < NUM_PLAYERS) begin : g_on
            uno_hand_store #(.HAND_CAP(HAND_CAP)) u_hand (
                .i_clk          (i_clk),
                .i_rst_n        (i_rst_n),
                .i_clear        (h_clear[p]),
                .i_append       (h_append[p]),
                .i_card         (card_t'(i_deck_card)),
                .i_remove       (h_remove[p]),
                .i_remove_idx   (IDX_W'(i_play_idx)),
                .o_removed_card (h_removed[p]),
                .o_remove_ok    (h_remove_ok[p]),
                .o_full         (h_full[p]),
                .o_count        (h_count[p]),
                .i_rd_idx       (IDX_W'(i_rd_idx)),
                .o_rd_card      (h_rd[p])
            );
        end else begin : g_off
            // A missing seat behaves as a permanently full, empty hand
            assign h_full[p]      = 1'b1;
            assign h_remove_ok[p] = 1'b0;
            assign h_count[p]     = '0;
            assign h_removed[p]   = '0;
            assign h_rd[p]        = '0;
        end
    end

`ifdef UNO_DEALER_FIRST_CARD_EN
    logic       top_wait;
    logic [5:0] top_card;
    assign o_top_card = top_card;
`else
    assign o_top_card = '0;
`endif

    // Sequence deal/draw transactions and keep the sticky/status registers
    // NOTE: all state here uses non-blocking assignment so every register
    // samples pre-edge values; later assignments to the same register win.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            player        <= '0;
            round         <= '0;
            remaining     <= '0;
            deal_mode     <= 1'b0;
            o_done        <= 1'b0;
            o_overflow    <= 1'b0;
            o_played_card <= '0;
`ifdef UNO_DEALER_FIRST_CARD_EN
            top_wait      <= 1'b0;
            top_card      <= '0;
`endif
        end else begin
            o_done <= (state == S_FIN);
            case (state)
                S_IDLE: begin
                    if (i_play) begin
                        if (h_remove_ok[i_play_player]) begin
                            o_played_card <= h_removed[i_play_player];
                        end
                    end else if (i_deal_start) begin
                        player     <= '0;
                        round      <= '0;
                        remaining  <= DRAW_ONE;
                        deal_mode  <= 1'b1;
                        o_overflow <= 1'b0;
                        state      <= S_ISSUE;
                    end else if (i_req) begin
                        player    <= i_req_player;
                        remaining <= i_req_count;
                        deal_mode <= 1'b0;
                        state     <= (i_req_count == 3'd0) ? S_FIN : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i_deck_done) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_deck_drawn) begin
                        if (h_full[player]) begin
                            o_overflow <= 1'b1;
                        end
                        remaining <= remaining - 1'b1;
                        if (remaining == 3'd1) begin
                            if (!deal_mode) begin
                                state <= S_FIN;
                            end else if (!deal_last) begin
                                if (player == LAST_PLAYER) begin
                                    player <= '0;
                                    round  <= round + 1'b1;
                                end else begin
                                    player <= player + 1'b1;
                                end
                                remaining <= DRAW_ONE;
                                state     <= S_ISSUE;
                            end else begin
`ifdef UNO_DEALER_FIRST_CARD_EN
                                top_wait <= 1'b0;
                                state    <= S_TOP;
`else
                                state    <= S_FIN;
`endif
                            end
                        end
                    end
                end
`ifdef UNO_DEALER_FIRST_CARD_EN
                S_TOP: begin
                    if (!top_wait) begin
                        if (i_deck_done) begin
                            top_wait <= 1'b1;
                        end
                    end else if (i_deck_drawn) begin
                        top_card <= i_deck_card;
                        if (is_wild(card_t'(i_deck_card))) begin
                            top_wait <= 1'b0;
                        end else begin
                            state <= S_FIN;
                        end
                    end
                end
`endif
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Draw count goes to the deck only in the cycle the deck reports idle
    always_comb begin
        o_deck_draw = '0;
        if ((state == S_ISSUE) && i_deck_done) begin
            o_deck_draw = remaining;
        end
`ifdef UNO_DEALER_FIRST_CARD_EN
        if ((state == S_TOP) && !top_wait && i_deck_done) begin
            o_deck_draw = DRAW_ONE;
        end
`endif
    end

    assign o_busy      = (state != S_IDLE);
    assign o_req_ready = (state == S_IDLE) && !i_play;
    assign o_rd_card   = h_rd[i_rd_player];
    assign o_rd_count  = 6'(h_count[i_rd_player]);

endmodule

// File: tb/tb_uno_dealer.sv
// Directed testbench for uno_dealer with a behavioural deck that answers
// every other cycle. Build with UNO_DEALER_FIRST_CARD_EN to cover the
// starter-card feature.
module tb_uno_dealer;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_deal_start, i_req, i_play;
    logic [1:0] i_req_player, i_play_player, i_rd_player;
    logic [2:0] i_req_count;
    logic [4:0] i_play_idx, i_rd_idx;
    logic       o_req_ready, o_busy, o_done, o_overflow;
    logic [5:0] o_played_card, o_rd_card, o_rd_count, o_top_card;
    logic [2:0] o_deck_draw;
    logic       i_deck_done, i_deck_drawn;
    logic [5:0] i_deck_card;

`ifdef UNO_DEALER_FIRST_CARD_EN
    localparam int         EXP_DEAL_DRAWS = 30;
    localparam logic [5:0] EXP_TOP        = 6'h25;
`else
    localparam int         EXP_DEAL_DRAWS = 28;
    localparam logic [5:0] EXP_TOP        = 6'h00;
`endif

    uno_dealer dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_deal_start  (i_deal_start),
        .i_req         (i_req),
        .i_req_player  (i_req_player),
        .i_req_count   (i_req_count),
        .o_req_ready   (o_req_ready),
        .i_play        (i_play),
        .i_play_player (i_play_player),
        .i_play_idx    (i_play_idx),
        .o_played_card (o_played_card),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_overflow    (o_overflow),
        .o_deck_draw   (o_deck_draw),
        .i_deck_done   (i_deck_done),
        .i_deck_drawn  (i_deck_drawn),
        .i_deck_card   (i_deck_card),
        .i_rd_player   (i_rd_player),
        .i_rd_idx      (i_rd_idx),
        .o_rd_card     (o_rd_card),
        .o_rd_count    (o_rd_count),
        .o_top_card    (o_top_card)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Deck model: scripted cards first, then an incrementing counter
    logic [5:0] deck_q[$];
    logic [5:0] deck_next = 6'h30;
    int pending = 0;
    bit phase = 1'b0;
    bit drew_prev = 1'b0;
    int draw_events = 0;
    int draw_non1 = 0;
    int back_to_back = 0;
    int proto_err = 0;
    logic [2:0] last_draw = '0;

    initial begin
        i_deck_done  = 1'b1;
        i_deck_drawn = 1'b0;
        i_deck_card  = '0;
        forever begin
            @(negedge i_clk);
            if (pending > 0) begin
                i_deck_done = 1'b0;
                if (phase) begin
                    i_deck_drawn = 1'b1;
                    if (deck_q.size() > 0) begin
                        i_deck_card = deck_q.pop_front();
                    end else begin
                        i_deck_card = deck_next;
                        deck_next   = deck_next + 6'd1;
                    end
                    pending--;
                end else begin
                    i_deck_drawn = 1'b0;
                end
                phase = !phase;
            end else begin
                i_deck_done  = 1'b1;
                i_deck_drawn = 1'b0;
            end
            #1;
            if (i_rst_n && o_deck_draw != 3'd0) begin
                if (!i_deck_done) proto_err++;
                if (drew_prev) back_to_back++;
                if (o_deck_draw != 3'd1) draw_non1++;
                draw_events++;
                last_draw = o_deck_draw;
                pending   = int'(o_deck_draw);
                phase     = 1'b0;
                drew_prev = 1'b1;
            end else begin
                drew_prev = 1'b0;
            end
        end
    end

    int done_cnt = 0;
    always @(negedge i_clk) begin
        if (o_done) done_cnt++;
    end

    task automatic wait_done(input string name, input int max_cycles);
        int n = 0;
        while (!o_done && n < max_cycles) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: o_done not seen within %0d cycles", name, max_cycles);
        end
    endtask

    task automatic do_req(input logic [1:0] p, input logic [2:0] c);
        int n = 0;
        while (!o_req_ready && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        i_req = 1'b1; i_req_player = p; i_req_count = c;
        @(negedge i_clk);
        i_req = 1'b0;
        wait_done("req_done", 300);
        repeat (2) @(negedge i_clk);
    endtask

    task automatic do_play(input logic [1:0] p, input logic [4:0] idx);
        i_play = 1'b1; i_play_player = p; i_play_idx = idx;
        @(negedge i_clk);
        i_play = 1'b0;
    endtask

    task automatic rd(input logic [1:0] p, input logic [4:0] idx);
        i_rd_player = p;
        i_rd_idx    = idx;
        #1;
    endtask

    typedef struct {
        logic [1:0] player;
        logic [4:0] idx;
        logic [5:0] card;
    } rd_vec_t;

    rd_vec_t vecs[9];
    int d0, e0;

    initial begin
        // Hand contents after the opening deal: hand p slot k holds card 4k+p
        vecs[0] = '{2'd0, 5'd0, 6'h00};
        vecs[1] = '{2'd0, 5'd1, 6'h04};
        vecs[2] = '{2'd0, 5'd6, 6'h18};
        vecs[3] = '{2'd0, 5'd7, 6'h00};
        vecs[4] = '{2'd1, 5'd0, 6'h01};
        vecs[5] = '{2'd2, 5'd3, 6'h0E};
        vecs[6] = '{2'd2, 5'd6, 6'h1A};
        vecs[7] = '{2'd3, 5'd0, 6'h03};
        vecs[8] = '{2'd3, 5'd6, 6'h1B};

        for (int i = 0; i < 28; i++) deck_q.push_back(6'(i));
`ifdef UNO_DEALER_FIRST_CARD_EN
        deck_q.push_back(6'h0D);
        deck_q.push_back(6'h25);
`endif

        i_rst_n = 1'b0;
        i_deal_start = 1'b0; i_req = 1'b0; i_play = 1'b0;
        i_req_player = '0; i_req_count = '0;
        i_play_player = '0; i_play_idx = '0;
        i_rd_player = '0; i_rd_idx = '0;
        repeat (3) @(negedge i_clk);

        // Reset state
        check("rst_busy", o_busy, 0);
        check("rst_ready", o_req_ready, 1);
        check("rst_done", o_done, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_played", o_played_card, 0);
        check("rst_top", o_top_card, 0);
        check("rst_draw", o_deck_draw, 0);
        rd(2'd3, 5'd31);
        check("rst_count", o_rd_count, 0);
        check("rst_card", o_rd_card, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Opening deal
        d0 = done_cnt;
        i_deal_start = 1'b1;
        @(negedge i_clk);
        i_deal_start = 1'b0;
        check("deal_busy", o_busy, 1);
        wait_done("deal_done", 2000);
        repeat (3) @(negedge i_clk);
        check("deal_done_pulses", done_cnt - d0, 1);
        check("deal_draw_events", draw_events, EXP_DEAL_DRAWS);
        check("deal_draw_not_one", draw_non1, 0);
        check("deal_back_to_back", back_to_back, 0);
        check("deal_top_card", o_top_card, EXP_TOP);
        for (int p = 0; p < 4; p++) begin
            rd(2'(p), 5'd0);
            check($sformatf("deal_count_p%0d", p), o_rd_count, 7);
        end
        for (int i = 0; i < 9; i++) begin
            rd(vecs[i].player, vecs[i].idx);
            check($sformatf("deal_card_p%0d_s%0d", vecs[i].player, vecs[i].idx),
                  o_rd_card, vecs[i].card);
        end

        // Draw 4 to player 2: single count-4 request, cards 0x30..0x33
        d0 = done_cnt; e0 = draw_events;
        do_req(2'd2, 3'd4);
        check("draw4_events", draw_events - e0, 1);
        check("draw4_value", last_draw, 4);
        check("draw4_done", done_cnt - d0, 1);
        rd(2'd2, 5'd7);
        check("draw4_count", o_rd_count, 11);
        check("draw4_slot7", o_rd_card, 6'h30);
        rd(2'd2, 5'd10);
        check("draw4_slot10", o_rd_card, 6'h33);

        // Fill hand 1 to exactly capacity, then overflow it
        do_req(2'd1, 3'd7);
        do_req(2'd1, 3'd7);
        do_req(2'd1, 3'd7);
        do_req(2'd1, 3'd4);
        rd(2'd1, 5'd0);
        check("fill_count", o_rd_count, 32);
        check("fill_no_overflow", o_overflow, 0);
        d0 = done_cnt;
        do_req(2'd1, 3'd2);
        rd(2'd1, 5'd0);
        check("ovf_flag", o_overflow, 1);
        check("ovf_count", o_rd_count, 32);
        check("ovf_done", done_cnt - d0, 1);

        // Play: swap-remove slot 2 of hand 0 (0x08 out, 0x18 in)
        do_play(2'd0, 5'd2);
        check("play_card", o_played_card, 6'h08);
        rd(2'd0, 5'd2);
        check("play_slot2", o_rd_card, 6'h18);
        check("play_count", o_rd_count, 6);
        do_play(2'd0, 5'd9);
        rd(2'd0, 5'd0);
        check("play_idx9_card", o_played_card, 6'h08);
        check("play_idx9_count", o_rd_count, 6);
        do_play(2'd0, 5'd6);
        rd(2'd0, 5'd0);
        check("play_idx_eq_count", o_rd_count, 6);
        do_play(2'd0, 5'd5);
        rd(2'd0, 5'd0);
        check("play_last_card", o_played_card, 6'h14);
        check("play_last_count", o_rd_count, 5);

        // Play and request in the same cycle: play wins, request dropped
        e0 = draw_events;
        i_play = 1'b1; i_play_player = 2'd3; i_play_idx = 5'd0;
        i_req = 1'b1; i_req_player = 2'd0; i_req_count = 3'd1;
        #1;
        check("both_ready", o_req_ready, 0);
        @(negedge i_clk);
        i_play = 1'b0; i_req = 1'b0;
        check("both_idle", o_busy, 0);
        check("both_played", o_played_card, 6'h03);
        repeat (6) @(negedge i_clk);
        check("both_no_draw", draw_events - e0, 0);
        rd(2'd0, 5'd0);
        check("both_p0_count", o_rd_count, 5);
        rd(2'd3, 5'd0);
        check("both_p3_count", o_rd_count, 6);
        check("both_p3_slot0", o_rd_card, 6'h1B);

        // Zero-count request: no deck traffic, still one o_done
        d0 = done_cnt; e0 = draw_events;
        do_req(2'd0, 3'd0);
        check("zero_done", done_cnt - d0, 1);
        check("zero_draws", draw_events - e0, 0);

        // Second deal clears overflow/counts; inputs while busy are ignored
        i_deal_start = 1'b1;
        @(negedge i_clk);
        i_deal_start = 1'b0;
        check("redeal_busy", o_busy, 1);
        check("redeal_ovf_clear", o_overflow, 0);
        i_req = 1'b1; i_req_player = 2'd0; i_req_count = 3'd4;
        i_play = 1'b1; i_play_player = 2'd0; i_play_idx = 5'd0;
        @(negedge i_clk);
        i_req = 1'b0; i_play = 1'b0;
        wait_done("redeal_done", 3000);
        repeat (6) @(negedge i_clk);
        check("redeal_idle", o_busy, 0);
        for (int p = 0; p < 4; p++) begin
            rd(2'(p), 5'd0);
            check($sformatf("redeal_count_p%0d", p), o_rd_count, 7);
        end
        check("proto_draw_when_busy", proto_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
